pipelined_addsub: RTL

- Parametrised successor to the 4-bit ripple-carry adder: WIDTH-bit adder/subtractor split into STAGES carry-chained slices, one slice per pipeline stage.
- Accepts one operation per cycle under a valid/ready handshake and returns sum, carry/borrow and signed overflow.
- Latency is STAGES cycles.
- Serves as the arithmetic datapath building block for wider lab datapaths (accumulators, ALUs).

---
 rtl/pipelined_addsub.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/pipelined_addsub.sv
// pipelined_addsub: WIDTH-bit adder/subtractor split into STAGES carry-chained
// slices, one slice per pipeline stage, behind a valid/ready handshake.
// Each stage k adds slice k of A and of the conditionally inverted B, plus the
// carry registered by stage k-1. Upper operand slices ride along with the
// operation until their stage, and finished lower sum slices ride along until
// the last stage, so every slice of one operation leaves together.
module pipelined_addsub #(
  parameter int WIDTH  = 16,
  parameter int STAGES = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] s,
  output logic             cout,
  output logic             ovf
);

  localparam int ST    = (STAGES < 1) ? 1 : STAGES;
  localparam int CHUNK = WIDTH / ST;
  localparam int LAST  = ST - 1;

  if ((STAGES < 1) || ((WIDTH % ST) != 0)) begin : g_cfg_err
    $error("pipelined_addsub: WIDTH (%0d) must be a multiple of STAGES (%0d), STAGES >= 1",
           WIDTH, STAGES);
  end

  // Whole-pipe shift enable: the output slot is empty or being drained.
  logic advance;

  // Per-stage inputs: stage 0 sees the ports, stage k sees stage k-1's registers.
  logic [WIDTH-1:0] a_in   [ST];
  logic [WIDTH-1:0] b_in   [ST];
  logic [WIDTH-1:0] s_in   [ST];
  logic [ST-1:0]    c_in;
  logic [ST-1:0]    sub_in;
  logic [ST-1:0]    vld_in;

  // Per-stage registers. a/b carry the not-yet-consumed operand slices, s the
  // sum slices finished so far, c the carry out of this stage's slice.
  logic [WIDTH-1:0] a_q [ST];
  logic [WIDTH-1:0] a_d [ST];
  logic [WIDTH-1:0] b_q [ST];
  logic [WIDTH-1:0] b_d [ST];
  logic [WIDTH-1:0] s_q [ST];
  logic [WIDTH-1:0] s_d [ST];
  logic [ST-1:0]    c_q;
  logic [ST-1:0]    c_d;
  logic [ST-1:0]    sub_q;
  logic [ST-1:0]    sub_d;
  logic [ST-1:0]    vld_q;
  logic [ST-1:0]    vld_d;
  logic [ST-1:0]    ovf_q;
  logic [ST-1:0]    ovf_d;

  assign advance   = !vld_q[LAST] || out_ready;
  assign in_ready  = advance;

  assign out_valid = vld_q[LAST];
  assign s         = s_q[LAST];
  // Subtraction runs as A + ~B + ~cin, so the borrow is the inverted carry.
  assign cout      = c_q[LAST] ^ sub_q[LAST];
  assign ovf       = ovf_q[LAST];

  for (genvar k = 0; k < ST; k++) begin : g_link
    if (k == 0) begin : g_head
      assign a_in[k]   = a;
      assign b_in[k]   = b ^ {WIDTH{sub}};
      assign s_in[k]   = '0;
      assign c_in[k]   = cin ^ sub;
      assign sub_in[k] = sub;
      assign vld_in[k] = in_valid;
    end else begin : g_body
      assign a_in[k]   = a_q[k-1];
      assign b_in[k]   = b_q[k-1];
      assign s_in[k]   = s_q[k-1];
      assign c_in[k]   = c_q[k-1];
      assign sub_in[k] = sub_q[k-1];
      assign vld_in[k] = vld_q[k-1];
    end
  end

  // Slice adders and next-state selection: shift everything on advance, else hold.
  always_comb begin
    logic [CHUNK:0] sum_t;
    sum_t = '0;
    for (int k = 0; k < ST; k++) begin
      sum_t = {1'b0, a_in[k][k*CHUNK +: CHUNK]}
            + {1'b0, b_in[k][k*CHUNK +: CHUNK]}
            + {{CHUNK{1'b0}}, c_in[k]};
      a_d[k]   = a_q[k];
      b_d[k]   = b_q[k];
      s_d[k]   = s_q[k];
      c_d[k]   = c_q[k];
      sub_d[k] = sub_q[k];
      vld_d[k] = vld_q[k];
      ovf_d[k] = ovf_q[k];
      if (advance) begin
        a_d[k]                   = a_in[k];
        b_d[k]                   = b_in[k];
        s_d[k]                   = s_in[k];
        s_d[k][k*CHUNK +: CHUNK] = sum_t[CHUNK-1:0];
        c_d[k]                   = sum_t[CHUNK];
        sub_d[k]                 = sub_in[k];
        vld_d[k]                 = vld_in[k];
        // Sign-bit inputs and sum give the carry into the MSB; XOR with the
        // carry out is the signed overflow. Only the top slice's value is used.
        ovf_d[k]                 = a_in[k][k*CHUNK+CHUNK-1] ^ b_in[k][k*CHUNK+CHUNK-1]
                                 ^ sum_t[CHUNK-1] ^ sum_t[CHUNK];
      end
    end
  end

  // Operand skew registers: pure data, never reset.
  always_ff @(posedge clk) begin
    for (int k = 0; k < ST; k++) begin
      a_q[k] <= a_d[k];
      b_q[k] <= b_d[k];
    end
  end

  // Valid, carry, sum and flag registers: cleared by reset, discarding in-flight ops.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < ST; k++) begin
        s_q[k]   <= '0;
        c_q[k]   <= 1'b0;
        sub_q[k] <= 1'b0;
        vld_q[k] <= 1'b0;
        ovf_q[k] <= 1'b0;
      end
    end else begin
      for (int k = 0; k < ST; k++) begin
        s_q[k]   <= s_d[k];
        c_q[k]   <= c_d[k];
        sub_q[k] <= sub_d[k];
        vld_q[k] <= vld_d[k];
        ovf_q[k] <= ovf_d[k];
      end
    end
  end

endmodule
